div4_seq: RTL and testbench
===========================

DIV4_SEQ -- requirements
Module: div4_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the operand, quotient and remainder width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit: request a division; sampled only in IDLE or DONE.
REQ-005 The block SHALL have port dividend, input, WIDTH bits: unsigned numerator; sampled on the edge that accepts start.
REQ-006 The block SHALL have port divisor, input, WIDTH bits: unsigned denominator; sampled on the edge that accepts start.
REQ-007 The block SHALL have port busy, output, 1 bit: high while in RUN.
REQ-008 The block SHALL have port done, output, 1 bit: single-cycle pulse marking a valid result.
REQ-009 The block SHALL have port quotient, output, WIDTH bits: unsigned quotient.
REQ-010 The block SHALL have port remainder, output, WIDTH bits: unsigned remainder.
REQ-011 The block SHALL have port div_by_zero, output, 1 bit: high with the result when the captured divisor was 0.

Function
REQ-012 The block SHALL implement a three-state FSM: IDLE, RUN and DONE.
REQ-013 The FSM SHALL take these transitions: IDLE -> RUN on start=1; RUN -> DONE after exactly WIDTH iterations; DONE -> RUN on start=1; otherwise DONE -> IDLE.
REQ-014 On acceptance, the block SHALL capture the operands, clear the partial remainder (WIDTH+1 bits) and load the iteration counter to WIDTH.
REQ-015 In RUN, the block SHALL perform one restoring-division step per cycle, MSB first: shift {rem, q} left one bit; compute trial = rem - {0, divisor} (WIDTH+1 bits); if trial is non-negative, rem = trial and q LSB = 1; else rem is unchanged and q LSB = 0.
REQ-016 Latency SHALL be fixed: start accepted at edge E0; iterations at E1..E(WIDTH); done=1 for exactly the cycle following E(WIDTH), with busy=1 from E0 through E(WIDTH).
REQ-017 The quotient, remainder and div_by_zero outputs SHALL update only on entry to DONE and SHALL hold until the next entry to DONE or reset.
REQ-018 Divisor 0 SHALL follow the same latency and produce quotient = all ones, remainder = dividend and div_by_zero = 1; any nonzero divisor SHALL produce div_by_zero = 0.
REQ-019 Start while in RUN SHALL be ignored, with no effect on the operation in flight.
REQ-020 Start asserted in the DONE cycle SHALL be accepted, allowing back-to-back operations every WIDTH+1 cycles.
REQ-021 Operand inputs SHALL be don't-care outside the accepting edge; changing them in RUN SHALL NOT alter the result.
REQ-022 All arithmetic SHALL be unsigned, and the result SHALL satisfy dividend = quotient*divisor + remainder with remainder < divisor for every nonzero divisor.

Reset
REQ-023 rst_n low SHALL immediately force IDLE, with busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, counter=0 and internal registers cleared.
REQ-024 Reset asserted mid-operation SHALL abort the operation with no done pulse; the first start after reset release SHALL be accepted normally.

Structure
REQ-025 A shared package SHALL hold the FSM state enumeration, the default WIDTH constant and the divide-by-zero quotient constant (all ones).
REQ-026 The trial subtraction SHALL be a sub-module named sub_stage: a combinational (WIDTH+1)-bit subtractor returning the difference and a borrow/negative flag.
REQ-027 The FSM, counter and shift registers SHALL live in div4_seq.

Verification
REQ-028 Bench SHALL cover: dividend=13, divisor=3, start pulse -> done in the 5th cycle after E0, quotient=4, remainder=1, div_by_zero=0.
REQ-029 Bench SHALL cover: 15/1 -> quotient=15, remainder=0; 2/9 -> quotient=0, remainder=2.
REQ-030 Bench SHALL cover: 7/0 -> quotient=15, remainder=7, div_by_zero=1, same latency as a nonzero divide.
REQ-031 Bench SHALL cover: start re-pulsed with 9/2 during RUN of 13/3 -> result stays 4 r1 and no second done; then start in the DONE cycle with 9/2 -> next done gives 4 r1.
REQ-032 Bench SHALL cover: rst_n pulsed low at E2 of 14/5 -> outputs zero at once, no done pulse, and a following 14/5 gives 2 r4.
REQ-033 Bench SHALL cover: exhaustive sweep of all 256 operand pairs -> every result satisfies REQ-018 and REQ-022, with done exactly once per accepted start.

Source files
------------

// File: rtl/div4_seq_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div4_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 4;

    // Sliced down to WIDTH bits where used.
    localparam logic [63:0] DBZ_QUOTIENT = '1;

endpackage

// File: rtl/div4_seq_sub_stage.sv
// Combinational trial subtractor for one restoring-division step.
module sub_stage #(
    parameter int W = 5
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] diff,
    output logic         neg
);

    // The extra top bit of the widened subtraction is the borrow.
    always_comb begin
        {neg, diff} = {1'b0, a} - {1'b0, b};
    end

endmodule

// File: rtl/div4_seq.sv
// Sequential unsigned restoring divider: one quotient bit per cycle, MSB first,
// with a fixed WIDTH+1 cycle start-to-done latency.
module div4_seq
    import div4_seq_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t           state;
    logic [WIDTH:0]   rem_r;
    logic [WIDTH-1:0] quo_r;
    logic [WIDTH-1:0] dvs_r;
    logic [CW-1:0]    cnt;
    logic             dbz_r;

    logic [2*WIDTH:0] shift_all;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH-1:0] quo_sh;
    logic [WIDTH:0]   trial;
    logic             neg;
    logic [WIDTH:0]   rem_nxt;
    logic [WIDTH-1:0] quo_nxt;
    logic             cnt_last;

    // quo_r starts as the dividend and its bits shift into rem_r as quotient bits fill in.
    always_comb begin
        shift_all = {rem_r, quo_r} << 1;
        rem_sh    = shift_all[2*WIDTH:WIDTH];
        quo_sh    = shift_all[WIDTH-1:0];
        rem_nxt   = neg ? rem_sh : trial;
        quo_nxt   = quo_sh | WIDTH'(!neg);
        cnt_last  = (cnt == CW'(1));
    end

    sub_stage #(
        .W(WIDTH + 1)
    ) u_sub (
        .a   (rem_sh),
        .b   ({1'b0, dvs_r}),
        .diff(trial),
        .neg (neg)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            rem_r       <= '0;
            quo_r       <= '0;
            dvs_r       <= '0;
            cnt         <= '0;
            dbz_r       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state <= RUN;
                        busy  <= 1'b1;
                        quo_r <= dividend;
                        dvs_r <= divisor;
                        rem_r <= '0;
                        cnt   <= CW'(WIDTH);
                        dbz_r <= (divisor == '0);
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    rem_r <= rem_nxt;
                    quo_r <= quo_nxt;
                    cnt   <= cnt - CW'(1);
                    if (cnt_last) begin
                        state       <= DONE;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        quotient    <= dbz_r ? DBZ_QUOTIENT[WIDTH-1:0] : quo_nxt;
                        remainder   <= rem_nxt[WIDTH-1:0];
                        div_by_zero <= dbz_r;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div4_seq.sv
// Randomized self-checking bench for div4_seq against an arithmetic reference model.
module tb_div4_seq;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int n_tests = 0;
    int n_fail  = 0;

    logic [W-1:0] prev_q = '0;
    logic [W-1:0] prev_r = '0;
    logic         prev_z = 1'b0;

    div4_seq #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: plain integer division with the divide-by-zero rule.
    function automatic logic [W-1:0] ref_q(input int a, input int b);
        return (b == 0) ? W'((1 << W) - 1) : W'(a / b);
    endfunction

    function automatic logic [W-1:0] ref_r(input int a, input int b);
        return (b == 0) ? W'(a) : W'(a % b);
    endfunction

    // Called at a negedge with the DUT in IDLE or DONE; returns at the negedge of the done cycle.
    task automatic do_op(input int a, input int b, input bit noise, input string tag);
        logic [W-1:0] eq, er;
        eq = ref_q(a, b);
        er = ref_r(a, b);
        start    = 1'b1;
        dividend = W'(a);
        divisor  = W'(b);
        @(negedge clk);
        check({tag, " busy_e0"}, busy, 1);
        check({tag, " done_e0"}, done, 0);
        check({tag, " hold_q"}, quotient, prev_q);
        check({tag, " hold_r"}, remainder, prev_r);
        for (int i = 1; i <= W; i++) begin
            if (noise) begin
                start    = 1'($urandom_range(0, 1));
                dividend = W'($urandom);
                divisor  = W'($urandom);
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            if (i < W) begin
                check({tag, " done_early"}, done, 0);
                check({tag, " busy_run"}, busy, 1);
            end
        end
        start = 1'b0;
        check({tag, " done"}, done, 1);
        check({tag, " busy_done"}, busy, 0);
        check({tag, " quotient"}, quotient, eq);
        check({tag, " remainder"}, remainder, er);
        check({tag, " dbz"}, div_by_zero, (b == 0));
        if (b != 0) check({tag, " identity"}, 32'(quotient) * 32'(b) + 32'(remainder), a);
        prev_q = eq;
        prev_r = er;
        prev_z = (b == 0);
    endtask

    task automatic idle_cycle(input string tag);
        start = 1'b0;
        @(negedge clk);
        check({tag, " no_second_done"}, done, 0);
        check({tag, " idle_busy"}, busy, 0);
        check({tag, " idle_hold_q"}, quotient, prev_q);
    endtask

    initial begin
        #2;
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst quotient", quotient, 0);
        check("rst remainder", remainder, 0);
        check("rst dbz", div_by_zero, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        do_op(13, 3, 1'b0, "13/3");
        idle_cycle("13/3");
        do_op(15, 1, 1'b0, "15/1");
        idle_cycle("15/1");
        do_op(2, 9, 1'b0, "2/9");
        idle_cycle("2/9");
        do_op(7, 0, 1'b0, "7/0");
        idle_cycle("7/0");

        // Start re-pulsed with 9/2 during RUN must not disturb 13/3.
        start = 1'b1; dividend = 4'd13; divisor = 4'd3;
        @(negedge clk);
        for (int i = 1; i <= W; i++) begin
            start = 1'b1; dividend = 4'd9; divisor = 4'd2;
            if (i == W) start = 1'b0;
            @(negedge clk);
            if (i < W) check("rerun done_early", done, 0);
        end
        check("rerun done", done, 1);
        check("rerun quotient", quotient, 4);
        check("rerun remainder", remainder, 1);
        prev_q = 4; prev_r = 1; prev_z = 0;
        do_op(9, 2, 1'b0, "b2b 9/2");
        idle_cycle("b2b 9/2");

        // Reset asynchronously just after E2 of 14/5.
        do_op(13, 3, 1'b0, "pre-rst");
        idle_cycle("pre-rst");
        start = 1'b1; dividend = 4'd14; divisor = 4'd5;
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst busy", busy, 0);
        check("midrst done", done, 0);
        check("midrst quotient", quotient, 0);
        check("midrst remainder", remainder, 0);
        check("midrst dbz", div_by_zero, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < W + 2; i++) begin
            @(negedge clk);
            check("postrst no_done", done, 0);
        end
        prev_q = '0; prev_r = '0; prev_z = 1'b0;
        do_op(14, 5, 1'b0, "14/5");
        idle_cycle("14/5");

        // Exhaustive sweep with input noise and random back-to-back starts.
        for (int a = 0; a < (1 << W); a++) begin
            for (int b = 0; b < (1 << W); b++) begin
                do_op(a, b, 1'b1, $sformatf("sweep %0d/%0d", a, b));
                if ($urandom_range(0, 1) == 0) idle_cycle("sweep");
            end
        end

        // Random operands, mixed gaps.
        for (int k = 0; k < 64; k++) begin
            int a, b;
            a = int'($urandom_range(0, (1 << W) - 1));
            b = int'($urandom_range(0, (1 << W) - 1));
            do_op(a, b, 1'b1, $sformatf("rand %0d/%0d", a, b));
            if ($urandom_range(0, 2) == 0) idle_cycle("rand");
        end
        idle_cycle("final");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
